cello_tt_sweeper: RTL
=====================

// Module: cello_tt_sweeper
// PURPOSE
//   Stimulus and response stage for a 4-input Cello gate netlist. On start, it steps
//   through all 16 input combinations on in1..in4 and waits a settle time after each
//   step. It then samples the netlist output, builds the observed 16-bit truth table
//   and compares it against an expected table. It drives the netlist inputs and
//   consumes its single output, and reports pass/fail to the characterisation controller.
// PARAMETERS
//   SETTLE_CYCLES  16        clocks between driving a combination and its first sample (>=1)
//   SAMPLES        3         consecutive samples taken per combination (1..15)
//   EXPECTED       16'h3B68  expected table; bit i = response to combination i
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   one-cycle pulse; begins a sweep (ignored while busy)
//   abort      in   1   level; return to IDLE at the next edge, results invalid
//   dut_out    in   1   netlist output, asynchronous to clk
//   in1..in4   out  1   netlist inputs
//   busy       out  1   high from the cycle after start until done
//   done       out  1   one-cycle pulse when a sweep completes (not asserted on abort)
//   tt_obs     out  16  observed table; bit i = settled response to combination i
//   mismatch   out  16  tt_obs ^ EXPECTED, valid when done
//   unstable   out  16  bit i set if the SAMPLES samples of combination i disagreed
//   pass       out  1   (mismatch==0)&&(unstable==0); registered, updates with done
// BEHAVIOUR
//   - Reset: every output is 0, FSM is in IDLE and the combination index idx is 0.
//   - Mapping: in1=idx[3], in2=idx[2], in3=idx[1], in4=idx[0]. The inputs are
//     registered and change only on the APPLY edge.
//   - dut_out passes through a 2-flop synchronizer. All samples use the synchronized bit.
//   - FSM:
//       IDLE: on start, go to APPLY with idx=0. Clear tt_obs, mismatch, unstable and pass.
//       APPLY (1 cycle): drive idx onto in1..in4, load the settle counter with
//         SETTLE_CYCLES-1, go to SETTLE.
//       SETTLE: decrement the counter. At 0, go to SAMPLE with the sample counter at 0.
//       SAMPLE: 1 sample per cycle for SAMPLES cycles. The first sample is stored as ref.
//         Any later sample != ref sets unstable[idx]. After the last sample, set
//         tt_obs[idx]=ref and go to NEXT.
//       NEXT: if idx==15, go to DONE. Otherwise idx++ (no wrap) and go to APPLY.
//       DONE (1 cycle): pulse done, register mismatch and pass, go to IDLE. The
//         outputs hold until the next start.
//   - Latency per combination: 1 + SETTLE_CYCLES + SAMPLES + 1 cycles.
//     Whole sweep: 16*(SETTLE_CYCLES+SAMPLES+2)+1 cycles from start to done.
//   - busy is 1 in every state except IDLE.
//   - start while busy is ignored; it does not restart the sweep.
//   - abort has priority over every transition:
//       go to IDLE, busy=0, no done;
//       tt_obs, unstable and mismatch keep partial values;
//       pass is forced to 0; in1..in4 are held.
//   - start and abort in the same cycle: abort wins and the FSM stays in IDLE.
//   - Reset mid-sweep: immediate return to the reset state. The netlist inputs
//     also go to 0.
//   - Counters are sized with $clog2 and must not overflow at the maximum
//     parameter values.
// TESTING
//   1. Bench model returns EXPECTED[idx]; pulse start -> done after 16*(16+3+2)+1=337
//      cycles, tt_obs=16'h3B68, mismatch=0, unstable=0, pass=1.
//   2. Model inverts combination 5 -> tt_obs=16'h3B48, mismatch=16'h0020, pass=0.
//   3. Model toggles dut_out during the SAMPLE window of idx 9 -> unstable=16'h0200,
//      pass=0; tt_obs[9] equals the first sample.
//   4. Model delays its response by 12 cycles with SETTLE_CYCLES=16 -> pass=1.
//      Rerun with SETTLE_CYCLES=4 -> mismatch is nonzero.
//   5. Abort asserted during idx 7 -> busy falls next cycle, no done, pass=0;
//      a new start then completes with pass=1.
//   6. start re-pulsed at cycle 100 of a sweep -> ignored, done still at cycle 337.
//      rst_n low mid-sweep -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cello_tt_sweeper_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cello_tt_sweeper_if                                             |
// | Brief  : Control, status and netlist-facing signals of the sweeper.      |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
interface cello_tt_sweeper_if;
  logic        start;
  logic        abort;
  logic        dut_out;
  logic        in1;
  logic        in2;
  logic        in3;
  logic        in4;
  logic        busy;
  logic        done;
  logic [15:0] tt_obs;
  logic [15:0] mismatch;
  logic [15:0] unstable;
  logic        pass;

  // Controller side; it also hosts the netlist, so it returns dut_out
  modport master (
    output start, abort, dut_out,
    input  in1, in2, in3, in4, busy, done, tt_obs, mismatch, unstable, pass
  );

  modport slave (
    input  start, abort, dut_out,
    output in1, in2, in3, in4, busy, done, tt_obs, mismatch, unstable, pass
  );
endinterface
`default_nettype wire

// File: rtl/cello_tt_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cello_tt_sweeper                                                |
// | Brief  : Sweeps 16 input combinations of a 4-input gate netlist and      |
// |          checks the settled truth table against EXPECTED.                |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module cello_tt_sweeper #(
  parameter int          SETTLE_CYCLES = 16,
  parameter int          SAMPLES       = 3,
  parameter logic [15:0] EXPECTED      = 16'h3B68
) (
  input logic               clk,
  input logic               rst_n,
  cello_tt_sweeper_if.slave bus
);

  localparam int c_scw = $clog2(SETTLE_CYCLES + 1);
  localparam int c_smw = $clog2(SAMPLES + 1);
  localparam logic [c_scw-1:0] c_settle_load = c_scw'(SETTLE_CYCLES - 1);
  localparam logic [c_smw-1:0] c_smp_last    = c_smw'(SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_idx;
  logic [3:0]         r_in;
  logic [c_scw-1:0]   r_settle_cnt;
  logic [c_smw-1:0]   r_smp_cnt;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_ref;
  logic               r_done;
  logic               r_pass;
  logic [15:0]        r_tt_obs;
  logic [15:0]        r_mismatch;
  logic [15:0]        r_unstable;
  logic               w_sample;

  // dut_out is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.dut_out;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.start) w_state_nxt = S_APPLY;
        S_APPLY:  w_state_nxt = S_SETTLE;
        S_SETTLE: if (r_settle_cnt == '0) w_state_nxt = S_SAMPLE;
        S_SAMPLE: if (r_smp_cnt == c_smp_last) w_state_nxt = S_NEXT;
        S_NEXT:   w_state_nxt = (r_idx == 4'hF) ? S_DONE : S_APPLY;
        S_DONE:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // With a single sample the live bit is its own reference
  assign w_sample = (r_smp_cnt == '0) ? r_sync2 : r_ref;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= 4'd0;
      r_in         <= 4'd0;
      r_settle_cnt <= '0;
      r_smp_cnt    <= '0;
      r_ref        <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_tt_obs     <= 16'd0;
      r_mismatch   <= 16'd0;
      r_unstable   <= 16'd0;
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_pass <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_idx      <= 4'd0;
              r_tt_obs   <= 16'd0;
              r_mismatch <= 16'd0;
              r_unstable <= 16'd0;
              r_pass     <= 1'b0;
            end
          end
          S_APPLY: begin
            r_in         <= r_idx;
            r_settle_cnt <= c_settle_load;
          end
          S_SETTLE: begin
            if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - 1'b1;
            else                    r_smp_cnt    <= '0;
          end
          S_SAMPLE: begin
            if (r_smp_cnt == '0)
              r_ref <= r_sync2;
            else if (r_sync2 != r_ref)
              r_unstable[r_idx] <= 1'b1;
            if (r_smp_cnt == c_smp_last)
              r_tt_obs[r_idx] <= w_sample;
            else
              r_smp_cnt <= r_smp_cnt + 1'b1;
          end
          S_NEXT: begin
            if (r_idx != 4'hF) r_idx <= r_idx + 1'b1;
          end
          S_DONE: begin
            r_done     <= 1'b1;
            r_mismatch <= r_tt_obs ^ EXPECTED;
            r_pass     <= (r_tt_obs == EXPECTED) && (r_unstable == 16'd0);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in1      = r_in[3];
  assign bus.in2      = r_in[2];
  assign bus.in3      = r_in[1];
  assign bus.in4      = r_in[0];
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.tt_obs   = r_tt_obs;
  assign bus.mismatch = r_mismatch;
  assign bus.unstable = r_unstable;
  assign bus.pass     = r_pass;

endmodule
`default_nettype wire
